adc_spi_master: RTL and testbench
=================================

// Module: adc_spi_master
// PURPOSE
//  Sequencer for the MAX19777/MAX11131-style serial ADC on the SDR front end.
//  Generates nCS and SCLK, shifts in each 16-bit frame from the ADC DOUT line, and emits 12-bit samples with a valid strobe.
//  Runs single-shot (TRIG) or free-running (EN) at a programmable frame rate.
//  Sits between the ADC pins and the downstream DSP chain.
// PARAMETERS
//  CLK_DIV        2    system clocks per SCLK half-period (>=1); SCLK = CLK/(2*CLK_DIV)
//  SAMPLE_PERIOD  100  system clocks from one nCS fall to the next in free-run; values < 34*CLK_DIV act as 34*CLK_DIV
// PORTS
//  CLK           in   1   system clock; all logic on rising edge
//  nRST          in   1   synchronous, active-low reset
//  EN            in   1   free-run enable: back-to-back frames every SAMPLE_PERIOD clocks
//  TRIG          in   1   single-cycle pulse: start one frame if IDLE (ignored otherwise)
//  nCS           out  1   ADC chip select, active low; falling edge = sampling instant
//  SCLK          out  1   ADC serial clock, idles high
//  DIN           in   1   ADC DOUT; ADC changes it on SCLK falling edge
//  SAMPLE        out  12  last captured conversion result, MSB = frame bit 1
//  SAMPLE_VALID  out  1   one-clock pulse when SAMPLE updates
//  BUSY          out  1   high from frame start until return to IDLE/WAIT
//  FRAME_ERR     out  1   framing check result (see CONFIGURATION)
// BEHAVIOUR
//  Reset (nRST=0 at a CLK edge): nCS=1, SCLK=1, SAMPLE=0, SAMPLE_VALID=0, BUSY=0, FRAME_ERR=0, state=IDLE, counters=0.
//  Applies mid-frame too: the frame is abandoned, no SAMPLE_VALID.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> (WAIT | IDLE).
//   IDLE : nCS=1, SCLK=1. (EN | TRIG) -> SETUP. EN and TRIG together = one start.
//   SETUP: nCS=0, SCLK=1 for CLK_DIV clocks; BUSY=1; period counter restarts at nCS fall.
//   SHIFT: 16 SCLK periods, each is CLK_DIV clocks low then CLK_DIV clocks high.
//          DIN is sampled on the CLK edge where SCLK goes 0->1.
//          Capture k (k=1..16) is frame bit b=k-1:
//            b=0      leading zero
//            b=1..12  data, MSB first
//            b=13,14  trailing zeros
//            b=15     high-Z, discarded
//   HOLD : nCS=1, SCLK=1 for CLK_DIV clocks. On the first HOLD clock: SAMPLE updated, SAMPLE_VALID=1 for 1 clock.
//          After HOLD: EN=1 -> WAIT, else IDLE.
//   WAIT : nCS=1, SCLK=1, BUSY=0. -> SETUP when the period counter reaches SAMPLE_PERIOD (effective).
//          EN=0 -> IDLE.
//  Frame length: 34*CLK_DIV clocks, nCS fall to HOLD end.
//  SAMPLE_VALID latency: 33*CLK_DIV clocks after nCS fall.
//  EN falling mid-frame: frame completes normally, then IDLE. TRIG during a frame or WAIT is ignored.
//  Period counter: >= 16 bits, saturating, never wraps within a period.
//  SCLK and nCS are driven from registers; no glitches, no combinational paths to pins.
// CONFIGURATION
//  ADC_FRAME_CHECK_EN defined:
//   - FRAME_ERR updates with SAMPLE_VALID.
//   - FRAME_ERR=1 iff frame bit 0, 13 or 14 was 1; otherwise 0.
//   - SAMPLE still updates on error.
//  ADC_FRAME_CHECK_EN undefined:
//   - FRAME_ERR tied 0.
//   - bits 0, 13, 14 are not stored.
// TESTING
//  Use an ADC emulator that returns an incrementing 12-bit count per nCS fall.
//  1. Reset, TRIG pulse, CLK_DIV=2 -> single frame; nCS low 66 clocks; 16 SCLK rises;
//     SAMPLE=12'h001, one VALID pulse; return to IDLE.
//  2. EN=1, SAMPLE_PERIOD=100, CLK_DIV=2 -> nCS falls every 100 clocks; SAMPLE=1,2,3,...;
//     emulator wraps 12'hFFF->12'h000 and SAMPLE follows.
//  3. SAMPLE_PERIOD=10, CLK_DIV=1 -> frames back-to-back every 34 clocks (clamped period).
//  4. nRST low on SCLK rise #7 -> next clock nCS=1, SCLK=1, no VALID; SAMPLE stays 0.
//  5. EN dropped at SCLK rise #5 -> frame finishes, VALID pulses once, then IDLE, nCS stays high.
//  6. With ADC_FRAME_CHECK_EN: DIN forced 1 at bit 13 -> FRAME_ERR=1 with VALID;
//     next clean frame -> FRAME_ERR=0. Without the macro -> FRAME_ERR always 0.

Source files
------------

// File: rtl/adc_spi_master.sv
// adc_spi_master: frame sequencer for a MAX11131-style serial ADC.
// Drives nCS/SCLK from registers, shifts in a 16-bit frame from DIN and
// publishes the 12 data bits as SAMPLE with a one-clock SAMPLE_VALID strobe.
// Optional feature macro: ADC_FRAME_CHECK_EN (frame bits 0/13/14 checked
// for zero and reported on FRAME_ERR; without it FRAME_ERR is tied low).
//
// Handshake: there is no backpressure. SAMPLE_VALID is a single-cycle strobe
// and SAMPLE holds its value until the next strobe; TRIG is accepted only in
// IDLE, and EN is level-sensitive and checked at frame boundaries.
module adc_spi_master #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        EN,
    input  logic        TRIG,
    output logic        nCS,
    output logic        SCLK,
    input  logic        DIN,
    output logic [11:0] SAMPLE,
    output logic        SAMPLE_VALID,
    output logic        BUSY,
    output logic        FRAME_ERR,
    output logic [2:0]  DBG_STATE
);

    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_CLKS = 34 * CLK_DIV;
    localparam int P_EFF      = (SAMPLE_PERIOD < FRAME_CLKS) ? FRAME_CLKS : SAMPLE_PERIOD;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // A new frame is launched one clock before the period elapses so that
    // the nCS fall itself lands exactly P_EFF clocks after the previous one.
    localparam logic [31:0]      PER_LAST = 32'(P_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            state_q;
    logic              ncs_q;
    logic              sclk_q;
    logic              busy_q;
    logic              valid_q;
    logic [11:0]       sample_q;
    logic [11:0]       data_q;
    logic [DIV_W-1:0]  div_q;
    logic [4:0]        bit_q;
    logic [31:0]       per_q;
    logic [31:0]       per_d;
    logic              div_last;
    logic              period_done;
    logic              start_frame;
`ifdef ADC_FRAME_CHECK_EN
    logic              err_q;
    logic              frame_err_q;
`endif

    // Phase/period decode and the frame-start decision shared by IDLE, HOLD and WAIT.
    always_comb begin
        div_last    = (div_q == DIV_LAST);
        period_done = (per_q >= PER_LAST);
        per_d       = (per_q == '1) ? per_q : per_q + 32'd1;
        start_frame = ((state_q == S_IDLE) && (EN || TRIG)) ||
                      ((state_q == S_HOLD) && div_last && EN && period_done) ||
                      ((state_q == S_WAIT) && EN && period_done);
    end

    // Frame sequencer: all pin-facing outputs are registered here.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            ncs_q       <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sample_q    <= '0;
            data_q      <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            per_q       <= '0;
`ifdef ADC_FRAME_CHECK_EN
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            per_q   <= per_d;
            case (state_q)
                S_IDLE: begin
                    ncs_q  <= 1'b1;
                    sclk_q <= 1'b1;
                end
                S_SETUP: begin
                    if (div_last) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (!div_last) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising SCLK: capture frame bit number bit_q.
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 5'd1;
                            if ((bit_q >= 5'd1) && (bit_q <= 5'd12)) begin
                                data_q <= {data_q[10:0], DIN};
                            end
`ifdef ADC_FRAME_CHECK_EN
                            if ((bit_q == 5'd0) || (bit_q == 5'd13) || (bit_q == 5'd14)) begin
                                err_q <= err_q | DIN;
                            end
`endif
                        end else if (bit_q == 5'd16) begin
                            ncs_q    <= 1'b1;
                            sample_q <= data_q;
                            valid_q  <= 1'b1;
`ifdef ADC_FRAME_CHECK_EN
                            frame_err_q <= err_q;
`endif
                            state_q  <= S_HOLD;
                        end else begin
                            sclk_q <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!div_last) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= EN ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!EN) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Frame launch overrides whatever the current state decided.
            if (start_frame) begin
                state_q <= S_SETUP;
                ncs_q   <= 1'b0;
                sclk_q  <= 1'b1;
                busy_q  <= 1'b1;
                div_q   <= '0;
                per_q   <= '0;
`ifdef ADC_FRAME_CHECK_EN
                err_q   <= 1'b0;
`endif
            end
        end
    end

    assign nCS          = ncs_q;
    assign SCLK         = sclk_q;
    assign BUSY         = busy_q;
    assign SAMPLE       = sample_q;
    assign SAMPLE_VALID = valid_q;
    assign DBG_STATE    = state_q;
`ifdef ADC_FRAME_CHECK_EN
    assign FRAME_ERR    = frame_err_q;
`else
    assign FRAME_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: two instances (CLK_DIV=2/PERIOD=100 and
// CLK_DIV=1/PERIOD=10), each fed by an ADC emulator returning an
// incrementing 12-bit count per nCS fall; samples are scoreboarded.
module tb_adc_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        en_a, trig_a, din_a, ncs_a, sclk_a, valid_a, busy_a, ferr_a;
    logic [11:0] sample_a;
    logic [2:0]  dbg_a;
    logic        en_b, trig_b, din_b, ncs_b, sclk_b, valid_b, busy_b, ferr_b;
    logic [11:0] sample_b;
    logic [2:0]  dbg_b;

    int checks = 0;
    int errors = 0;

    adc_spi_master #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) u_dut_a (
        .CLK(clk), .nRST(n_rst), .EN(en_a), .TRIG(trig_a), .nCS(ncs_a), .SCLK(sclk_a),
        .DIN(din_a), .SAMPLE(sample_a), .SAMPLE_VALID(valid_a), .BUSY(busy_a),
        .FRAME_ERR(ferr_a), .DBG_STATE(dbg_a)
    );

    adc_spi_master #(.CLK_DIV(1), .SAMPLE_PERIOD(10)) u_dut_b (
        .CLK(clk), .nRST(n_rst), .EN(en_b), .TRIG(trig_b), .nCS(ncs_b), .SCLK(sclk_b),
        .DIN(din_b), .SAMPLE(sample_b), .SAMPLE_VALID(valid_b), .BUSY(busy_b),
        .FRAME_ERR(ferr_b), .DBG_STATE(dbg_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC emulators: frame = {0, count[11:0], b13, 0, b15(high-Z, driven 1)}
    logic [11:0] adc_cnt_a = 12'd0;
    logic [11:0] adc_cnt_b = 12'd0;
    logic [15:0] frame_a, frame_b;
    int          idx_a = 0, idx_b = 0;
    logic        inject_a = 1'b0;
    logic [11:0] exp_a[$];
    logic [11:0] exp_b[$];
    logic        exp_err_a[$];
    logic        exp_err_b[$];

    initial begin
        din_a = 1'b0;
        din_b = 1'b0;
    end

    always @(negedge ncs_a) begin
        adc_cnt_a = adc_cnt_a + 12'd1;
        frame_a   = {1'b0, adc_cnt_a, inject_a, 1'b0, 1'b1};
        idx_a     = 0;
        exp_a.push_back(adc_cnt_a);
`ifdef ADC_FRAME_CHECK_EN
        exp_err_a.push_back(inject_a);
`else
        exp_err_a.push_back(1'b0);
`endif
    end

    always @(negedge sclk_a) begin
        if (ncs_a == 1'b0 && idx_a < 16) begin
            din_a = frame_a[15 - idx_a];
            idx_a++;
        end
    end

    always @(negedge ncs_b) begin
        adc_cnt_b = adc_cnt_b + 12'd1;
        frame_b   = {1'b0, adc_cnt_b, 1'b0, 1'b0, 1'b1};
        idx_b     = 0;
        exp_b.push_back(adc_cnt_b);
        exp_err_b.push_back(1'b0);
    end

    always @(negedge sclk_b) begin
        if (ncs_b == 1'b0 && idx_b < 16) begin
            din_b = frame_b[15 - idx_b];
            idx_b++;
        end
    end

    // Monitor A: frame timing measurements and scoreboard pop on VALID.
    int   cyc_a = 0, n_falls_a = 0, fall_cyc_a = 0, last_period_a = 0;
    int   low_len_a = 0, last_low_a = 0, rises_a = 0, last_rises_a = 0;
    int   valid_cnt_a = 0, last_lat_a = 0;
    logic prev_ncs_a = 1'b1, prev_sclk_a = 1'b1;

    always @(negedge clk) begin
        if (prev_ncs_a === 1'b1 && ncs_a === 1'b0) begin
            n_falls_a++;
            last_period_a = cyc_a - fall_cyc_a;
            fall_cyc_a    = cyc_a;
            rises_a       = 0;
            low_len_a     = 0;
        end
        if (ncs_a === 1'b0) begin
            low_len_a++;
            if (prev_sclk_a === 1'b0 && sclk_a === 1'b1) rises_a++;
        end
        if (prev_ncs_a === 1'b0 && ncs_a === 1'b1) begin
            last_low_a   = low_len_a;
            last_rises_a = rises_a;
        end
        if (valid_a === 1'b1) begin
            valid_cnt_a++;
            last_lat_a = cyc_a - fall_cyc_a;
            if (exp_a.size() == 0) begin
                chk("a_unexpected_valid", 32'(exp_a.size()), 32'd1);
            end else begin
                chk("a_sample", {20'd0, sample_a}, {20'd0, exp_a.pop_front()});
                chk("a_frame_err", {31'd0, ferr_a}, {31'd0, exp_err_a.pop_front()});
            end
        end
        prev_ncs_a  = ncs_a;
        prev_sclk_a = sclk_a;
        cyc_a++;
    end

    // Monitor B: period measurement and scoreboard pop on VALID.
    int   cyc_b = 0, n_falls_b = 0, fall_cyc_b = 0, last_period_b = 0, valid_cnt_b = 0;
    logic prev_ncs_b = 1'b1;

    always @(negedge clk) begin
        if (prev_ncs_b === 1'b1 && ncs_b === 1'b0) begin
            n_falls_b++;
            last_period_b = cyc_b - fall_cyc_b;
            fall_cyc_b    = cyc_b;
        end
        if (valid_b === 1'b1) begin
            valid_cnt_b++;
            if (exp_b.size() == 0) begin
                chk("b_unexpected_valid", 32'(exp_b.size()), 32'd1);
            end else begin
                chk("b_sample", {20'd0, sample_b}, {20'd0, exp_b.pop_front()});
                chk("b_frame_err", {31'd0, ferr_b}, {31'd0, exp_err_b.pop_front()});
            end
        end
        prev_ncs_b = ncs_b;
        cyc_b++;
    end

    int vc, nf;

    initial begin
        n_rst = 1'b0; en_a = 1'b0; trig_a = 1'b0; en_b = 1'b0; trig_b = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ncs", {31'd0, ncs_a}, 32'd1);
        chk("rst_sclk", {31'd0, sclk_a}, 32'd1);
        chk("rst_sample", {20'd0, sample_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ferr", {31'd0, ferr_a}, 32'd0);

        // Single-shot TRIG frame
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_busy_mid", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 200 && valid_cnt_a < 1; i++) @(negedge clk);
        chk("t1_valid_seen", 32'(valid_cnt_a), 32'd1);
        repeat (10) @(negedge clk);
        chk("t1_ncs_low_len", 32'(last_low_a), 32'd66);
        chk("t1_sclk_rises", 32'(last_rises_a), 32'd16);
        chk("t1_valid_latency", 32'(last_lat_a), 32'd66);
        chk("t1_sample", {20'd0, sample_a}, 32'h001);
        chk("t1_busy_end", {31'd0, busy_a}, 32'd0);
        repeat (100) @(negedge clk);
        chk("t1_one_frame", 32'(n_falls_a), 32'd1);
        chk("t1_one_valid", 32'(valid_cnt_a), 32'd1);
        chk("t1_ncs_idle", {31'd0, ncs_a}, 32'd1);

        // Reset during SCLK rise #7
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        for (int i = 0; i < 200 && !(ncs_a === 1'b0 && rises_a == 7); i++) @(negedge clk);
        chk("t4_reached_rise7", 32'(rises_a), 32'd7);
        vc = valid_cnt_a;
        n_rst = 1'b0;
        @(negedge clk);
        chk("t4_ncs", {31'd0, ncs_a}, 32'd1);
        chk("t4_sclk", {31'd0, sclk_a}, 32'd1);
        chk("t4_valid", {31'd0, valid_a}, 32'd0);
        chk("t4_sample", {20'd0, sample_a}, 32'd0);
        chk("t4_busy", {31'd0, busy_a}, 32'd0);
        exp_a.delete();
        exp_err_a.delete();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("t4_no_valid", 32'(valid_cnt_a), 32'(vc));
        chk("t4_sample_stays", {20'd0, sample_a}, 32'd0);

        // Free-run, period 100, counter wrap and bit-13 injection
        nf = n_falls_a;
        en_a = 1'b1;
        for (int i = 0; i < 20 && n_falls_a == nf; i++) @(negedge clk);
        chk("t2_first_fall", 32'(n_falls_a), 32'(nf + 1));
        for (int k = 0; k < 5; k++) begin
            nf = n_falls_a;
            for (int i = 0; i < 150 && n_falls_a == nf; i++) @(negedge clk);
            chk("t2_period", 32'(last_period_a), 32'd100);
            if (k == 0) adc_cnt_a = 12'hFFD;
            if (k == 1) inject_a = 1'b1;
            if (k == 2) inject_a = 1'b0;
            if (k == 3) chk("t2_wrap_fff", {20'd0, sample_a}, 32'hFFF);
            if (k == 4) chk("t2_wrap_000", {20'd0, sample_a}, 32'h000);
        end

        // EN dropped at SCLK rise #5
        for (int i = 0; i < 150 && !(ncs_a === 1'b0 && rises_a == 5); i++) @(negedge clk);
        chk("t5_reached_rise5", 32'(rises_a), 32'd5);
        en_a = 1'b0;
        vc = valid_cnt_a;
        nf = n_falls_a;
        for (int i = 0; i < 100 && valid_cnt_a == vc; i++) @(negedge clk);
        repeat (250) @(negedge clk);
        chk("t5_one_valid", 32'(valid_cnt_a), 32'(vc + 1));
        chk("t5_no_new_frame", 32'(n_falls_a), 32'(nf));
        chk("t5_ncs_high", {31'd0, ncs_a}, 32'd1);
        chk("t5_busy_low", {31'd0, busy_a}, 32'd0);

        // Clamped period with CLK_DIV=1
        nf = n_falls_b;
        en_b = 1'b1;
        for (int i = 0; i < 20 && n_falls_b == nf; i++) @(negedge clk);
        chk("t3_first_fall", 32'(n_falls_b), 32'(nf + 1));
        for (int k = 0; k < 3; k++) begin
            nf = n_falls_b;
            for (int i = 0; i < 60 && n_falls_b == nf; i++) @(negedge clk);
            chk("t3_period", 32'(last_period_b), 32'd34);
        end
        en_b = 1'b0;
        repeat (80) @(negedge clk);
        chk("t3_all_frames_valid", 32'(valid_cnt_b), 32'(n_falls_b));
        chk("t3_ncs_high", {31'd0, ncs_b}, 32'd1);

        chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
